// File: rtl/read_iq.sv
// Front end of the FM radio pipeline: assembles little-endian 16-bit I/Q byte
// quads from a byte FIFO and writes quantized I/Q word pairs in lockstep.
module read_iq #(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  input  logic                  i_full,
  input  logic                  q_full,
  output logic                  out_wr_en,
  output logic [DATA_WIDTH-1:0] i_out,
  output logic [DATA_WIDTH-1:0] q_out,
  output logic [31:0]           sample_count
);

  typedef enum logic [2:0] {
    S_I_LO  = 3'd0,
    S_I_HI  = 3'd1,
    S_Q_LO  = 3'd2,
    S_Q_HI  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_i_lo;
  logic [7:0]  r_i_hi;
  logic [7:0]  r_q_lo;
  logic [7:0]  r_q_hi;
  logic [31:0] r_sample_count;
  logic        w_byte_state;
  logic        w_pop;
  logic        w_write;

  // Sign-extend the 16-bit sample to the output width, then scale by 2^BITS.
  function automatic logic signed [DATA_WIDTH-1:0] quantize(input logic [7:0] hi,
                                                            input logic [7:0] lo);
    logic signed [15:0]           s;
    logic signed [DATA_WIDTH-1:0] ext;
    s   = signed'({hi, lo});
    ext = DATA_WIDTH'(s);
    return ext <<< BITS;
  endfunction

  assign w_byte_state = (r_state != S_WRITE);
  assign w_pop        = !reset && w_byte_state && !in_empty;
  assign w_write      = !reset && (r_state == S_WRITE) && !i_full && !q_full;

  assign in_rd_en     = w_pop;
  assign out_wr_en    = w_write;
  assign i_out        = quantize(r_i_hi, r_i_lo);
  assign q_out        = quantize(r_q_hi, r_q_lo);
  assign sample_count = r_sample_count;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_I_LO:  if (w_pop)   w_next = S_I_HI;
      S_I_HI:  if (w_pop)   w_next = S_Q_LO;
      S_Q_LO:  if (w_pop)   w_next = S_Q_HI;
      S_Q_HI:  if (w_pop)   w_next = S_WRITE;
      S_WRITE: if (w_write) w_next = S_I_LO;
      default:              w_next = S_I_LO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_I_LO;
      r_i_lo         <= 8'd0;
      r_i_hi         <= 8'd0;
      r_q_lo         <= 8'd0;
      r_q_hi         <= 8'd0;
      r_sample_count <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        case (r_state)
          S_I_LO:  r_i_lo <= in_dout;
          S_I_HI:  r_i_hi <= in_dout;
          S_Q_LO:  r_q_lo <= in_dout;
          S_Q_HI:  r_q_hi <= in_dout;
          default: ;
        endcase
      end
      if (w_write) r_sample_count <= r_sample_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_read_iq.sv
// Directed bench for read_iq: table of byte quads with stall options plus
// hand-written back-to-back and reset sequences.
module tb_read_iq;

  logic        clock;
  logic        reset;
  logic [7:0]  in_dout;
  logic        in_empty;
  logic        in_rd_en;
  logic        i_full;
  logic        q_full;
  logic        out_wr_en;
  logic [31:0] i_out;
  logic [31:0] q_out;
  logic [31:0] sample_count;

  read_iq #(.DATA_WIDTH(32), .BITS(10)) dut (
    .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .i_full(i_full), .q_full(q_full),
    .out_wr_en(out_wr_en), .i_out(i_out), .q_out(q_out),
    .sample_count(sample_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          gap;    // empty cycles before each byte
    int          fullc;  // full cycles before the write is allowed
    logic [1:0]  fsel;   // 0: q_full, 1: i_full, 2: both
    logic [31:0] ei, eq;
  } vec_t;

  vec_t        vecs[6];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pop_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_empty = 1'b1;
      #1;
      chk("rd_en_while_empty", 32'(in_rd_en), 32'd0);
      tick();
    end
    in_dout  = b;
    in_empty = 1'b0;
    #1;
    chk("rd_en_pop", 32'(in_rd_en), 32'd1);
    chk("wr_en_in_byte_state", 32'(out_wr_en), 32'd0);
    tick();
    in_empty = 1'b1;
  endtask

  task automatic do_write(input vec_t v);
    for (int c = 0; c < v.fullc; c++) begin
      q_full = (v.fsel != 2'd1);
      i_full = (v.fsel != 2'd0);
      #1;
      chk("wr_en_while_full", 32'(out_wr_en), 32'd0);
      chk("i_out_stable", i_out, v.ei);
      chk("q_out_stable", q_out, v.eq);
      tick();
    end
    q_full = 1'b0;
    i_full = 1'b0;
    #1;
    chk("wr_en_write", 32'(out_wr_en), 32'd1);
    chk("rd_en_in_write", 32'(in_rd_en), 32'd0);
    chk("i_out", i_out, v.ei);
    chk("q_out", q_out, v.eq);
    tick();
    exp_cnt = exp_cnt + 32'd1;
    chk("sample_count", sample_count, exp_cnt);
    chk("wr_en_after_write", 32'(out_wr_en), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h01, 8'h00, 8'hFF, 8'hFF, 0, 0, 2'd0, 32'h0000_0400, 32'hFFFF_FC00};
    vecs[1] = '{8'h00, 8'h80, 8'hFF, 8'h7F, 0, 0, 2'd0, 32'hFE00_0000, 32'h01FF_FC00};
    vecs[2] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 1, 0, 2'd0, 32'h0048_D000, 32'hFEAF_3400};
    vecs[3] = '{8'h01, 8'h00, 8'hFF, 8'hFF, 1, 0, 2'd0, 32'h0000_0400, 32'hFFFF_FC00};
    vecs[4] = '{8'hFF, 8'h7F, 8'h00, 8'h80, 0, 7, 2'd0, 32'h01FF_FC00, 32'hFE00_0000};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 0, 3, 2'd2, 32'h0000_0000, 32'h0000_0000};

    reset = 1'b1; in_dout = 8'h5A; in_empty = 1'b0; i_full = 1'b0; q_full = 1'b0;
    tick();
    tick();
    chk("reset_rd_en", 32'(in_rd_en), 32'd0);
    chk("reset_wr_en", 32'(out_wr_en), 32'd0);
    chk("reset_i_out", i_out, 32'd0);
    chk("reset_q_out", q_out, 32'd0);
    chk("reset_count", sample_count, 32'd0);
    in_empty = 1'b1;
    reset = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) begin
      pop_byte(vecs[k].b0, vecs[k].gap);
      pop_byte(vecs[k].b1, vecs[k].gap);
      pop_byte(vecs[k].b2, vecs[k].gap);
      pop_byte(vecs[k].b3, vecs[k].gap);
      do_write(vecs[k]);
    end

    // Three samples with in_empty held low: write in every fifth cycle.
    begin
      logic [7:0] bytes[12];
      bytes = '{8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'h7F,
                8'h34, 8'h12, 8'hCD, 8'hAB};
      for (int cyc = 0; cyc < 15; cyc++) begin
        in_empty = 1'b0;
        in_dout  = (cyc % 5 == 4) ? 8'hEE : bytes[(cyc / 5) * 4 + (cyc % 5)];
        #1;
        if (cyc % 5 == 4) begin
          chk("b2b_rd_en_write", 32'(in_rd_en), 32'd0);
          chk("b2b_wr_en", 32'(out_wr_en), 32'd1);
          chk("b2b_i_out", i_out, vecs[cyc / 5 + (cyc / 5 == 2 ? 0 : 0)].ei);
          chk("b2b_q_out", q_out, vecs[cyc / 5].eq);
        end else begin
          chk("b2b_rd_en_byte", 32'(in_rd_en), 32'd1);
          chk("b2b_wr_en_byte", 32'(out_wr_en), 32'd0);
        end
        tick();
      end
      in_empty = 1'b1;
      exp_cnt = exp_cnt + 32'd3;
      chk("b2b_count", sample_count, exp_cnt);
    end

    // Reset during a stalled write discards the sample.
    pop_byte(8'h11, 0);
    pop_byte(8'h22, 0);
    pop_byte(8'h33, 0);
    pop_byte(8'h44, 0);
    i_full = 1'b1;
    #1;
    chk("stall_wr_en", 32'(out_wr_en), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_full = 1'b0;
    exp_cnt = 32'd0;
    #1;
    chk("rst_write_wr_en", 32'(out_wr_en), 32'd0);
    chk("rst_write_count", sample_count, 32'd0);

    // Reset after two bytes of a sample, then a fresh sample.
    pop_byte(8'hAA, 0);
    pop_byte(8'hBB, 0);
    reset = 1'b1;
    #1;
    chk("rst_partial_wr_en", 32'(out_wr_en), 32'd0);
    tick();
    reset = 1'b0;
    pop_byte(8'h02, 0);
    pop_byte(8'h00, 0);
    pop_byte(8'h03, 0);
    pop_byte(8'h00, 0);
    do_write('{8'h02, 8'h00, 8'h03, 8'h00, 0, 0, 2'd0, 32'h0000_0800, 32'h0000_0C00});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
